// File: rtl/ldm_stm_sequencer.sv
// ARM7 LDM/STM block-transfer sequencer: walks the register list, issues ascending word beats
// and produces the base write-back value. Optional abort support under macro LDM_ABORT_EN.
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [15:0]       reg_list,
  input  logic [ADDR_W-1:0] base,
  input  logic [3:0]        base_idx,
  input  logic              up,
  input  logic              pre,
  input  logic              load,
  input  logic              wb,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [3:0]        reg_sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] addr,
  output logic              rf_we,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr
`ifdef LDM_ABORT_EN
  ,
  input  logic              mem_abort,
  output logic              aborted
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [15:0]       list_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic              load_q;
  logic              wb_q;
  logic              wb_keep_q;

  logic [4:0]        n_pop;
  logic [ADDR_W-1:0] four_n;
  logic [ADDR_W-1:0] start_addr;
  logic [3:0]        low_idx;
  logic [15:0]       list_rest;
  logic              accept;
  logic              beat_done;
  logic              abort_hit;

  always_comb begin
    n_pop = '0;
    for (int i = 0; i < 16; i++) begin
      n_pop = n_pop + 5'(reg_list[i]);
    end
  end

  assign four_n = ADDR_W'({n_pop, 2'b00});

  // Beats always ascend, so the start address is the lowest word of the block.
  always_comb begin
    start_addr = base;
    case ({up, pre})
      2'b10:   start_addr = base;
      2'b11:   start_addr = base + ADDR_W'(4);
      2'b00:   start_addr = base - four_n + ADDR_W'(4);
      default: start_addr = base - four_n;
    endcase
  end

  // Descending scan so the lowest set bit is the one left standing.
  always_comb begin
    low_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) low_idx = 4'(i);
    end
  end

  assign list_rest = list_q & (list_q - 16'd1);
  assign accept    = (state_q == S_IDLE) && start;

  // Memory handshake: mem_req is held with stable addr/mem_we/reg_sel until a cycle in which
  // mem_ready=1; that cycle's rising edge completes the beat and advances to the next register.
  assign beat_done = (state_q == S_XFER) && mem_ready;

`ifdef LDM_ABORT_EN
  assign abort_hit = beat_done && mem_abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (n_pop == 5'd0) ? S_DONE : S_XFER;
      end
      S_XFER: begin
        if (abort_hit)                          state_d = S_DONE;
        else if (beat_done && list_rest == '0)  state_d = wb_q ? S_WB : S_DONE;
      end
      S_WB:    state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      list_q    <= '0;
      addr_q    <= '0;
      wb_addr_q <= '0;
      load_q    <= 1'b0;
      wb_q      <= 1'b0;
      wb_keep_q <= 1'b0;
    end else if (accept) begin
      list_q    <= reg_list;
      addr_q    <= start_addr;
      wb_addr_q <= up ? (base + four_n) : (base - four_n);
      load_q    <= load;
      wb_q      <= wb;
      // A load into the base register overrides the write-back value.
      wb_keep_q <= ~(load & reg_list[base_idx]);
    end else if (beat_done) begin
      list_q <= abort_hit ? 16'd0 : list_rest;
      addr_q <= addr_q + ADDR_W'(4);
    end
  end

`ifdef LDM_ABORT_EN
  logic aborted_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)            aborted_q <= 1'b0;
    else if (accept)    aborted_q <= 1'b0;
    else if (abort_hit) aborted_q <= 1'b1;
  end

  assign aborted = aborted_q;
`endif

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign mem_req = (state_q == S_XFER);
  assign mem_we  = (state_q == S_XFER) && !load_q;
  assign reg_sel = low_idx;
  assign addr    = addr_q;
  assign rf_we   = beat_done && load_q && !abort_hit;
  assign wb_en   = (state_q == S_WB) && wb_keep_q;
  assign wb_addr = wb_addr_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: directed table, corner sequences and
// randomized transfers against a block-level transfer model.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base;
  logic [3:0]  base_idx;
  logic        up, pre, load, wb, mem_ready;
  logic        busy, done, mem_req, mem_we, rf_we, wb_en;
  logic [3:0]  reg_sel;
  logic [31:0] addr, wb_addr;
`ifdef LDM_ABORT_EN
  logic        mem_abort;
  logic        aborted;
`endif

  int checks = 0;
  int errors = 0;

  ldm_stm_sequencer #(.ADDR_W(32)) dut (
    .clk(clk), .clr(clr), .start(start), .reg_list(reg_list), .base(base),
    .base_idx(base_idx), .up(up), .pre(pre), .load(load), .wb(wb),
    .mem_ready(mem_ready), .busy(busy), .done(done), .reg_sel(reg_sel),
    .mem_req(mem_req), .mem_we(mem_we), .addr(addr), .rf_we(rf_we),
    .wb_en(wb_en), .wb_addr(wb_addr)
`ifdef LDM_ABORT_EN
    , .mem_abort(mem_abort), .aborted(aborted)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a transfer is n beats over the ascending word block [lo, lo+4n), registers in index order.
  task automatic run_xfer(input logic [15:0] rl, input logic [31:0] b, input logic [3:0] bi,
                          input logic u, input logic p, input logic l, input logic w,
                          input int mode, input bit noise,
                          output logic [31:0] first_addr, output logic [31:0] wbv);
    int regs[$];
    int n, k, stall, guard;
    logic [31:0] lo, exp_wb;
    bit rdy;
    regs = {};
    for (int i = 0; i < 16; i++) if (rl[i]) regs.push_back(i);
    n = regs.size();
    if (u) lo = p ? b + 32'd4 : b;
    else   lo = p ? b - 32'(4 * n) : b - 32'(4 * n) + 32'd4;
    exp_wb = u ? b + 32'(4 * n) : b - 32'(4 * n);
    first_addr = 'x;
    wbv = 'x;

    @(negedge clk);
    reg_list = rl; base = b; base_idx = bi; up = u; pre = p; load = l; wb = w;
    start = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0; stall = 0; guard = 0;
    while (k < n && guard < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = bit'($urandom_range(0, 1));
        default: rdy = !(k == 1 && stall < 2);
      endcase
      if (!rdy) stall++;
      mem_ready = rdy;
      if (noise) begin
        start = 1'($urandom_range(0, 1)); reg_list = 16'($urandom); base = $urandom;
        base_idx = 4'($urandom); up = 1'($urandom); pre = 1'($urandom);
        load = 1'($urandom); wb = 1'($urandom);
      end
      #1;
      if (k == 0) first_addr = addr;
      chk("xfer_busy", busy, 1);
      chk("xfer_mem_req", mem_req, 1);
      chk("xfer_mem_we", mem_we, !l);
      chk("xfer_addr", addr, lo + 32'(4 * k));
      chk("xfer_reg_sel", reg_sel, regs[k]);
      chk("xfer_rf_we", rf_we, l & rdy);
      chk("xfer_done", done, 0);
      chk("xfer_wb_en", wb_en, 0);
      if (rdy) k++;
      guard++;
      @(negedge clk);
    end
    if (k < n) chk("beat_timeout", k, n);
    start = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    if (w && n > 0) begin
      #1;
      chk("wb_en", wb_en, !(l && rl[bi]));
      chk("wb_addr", wb_addr, exp_wb);
      chk("wb_mem_req", mem_req, 0);
      chk("wb_rf_we", rf_we, 0);
      chk("wb_done", done, 0);
      wbv = wb_addr;
      @(negedge clk);
    end
    #1;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_mem_req", mem_req, 0);
    chk("done_wb_en", wb_en, 0);
    chk("done_rf_we", rf_we, 0);
`ifdef LDM_ABORT_EN
    chk("done_aborted", aborted, 0);
`endif
    @(negedge clk);
    #1;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_mem_req", mem_req, 0);
    mem_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] rl;
    logic [31:0] b;
    logic [3:0]  bi;
    logic        u, p, l, w;
    int          mode;
    logic [31:0] exp_first;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t tab[8];
  logic [31:0] fa, wv;

  initial begin
    tab[0] = '{16'h000E, 32'h1000, 4'd13, 1, 0, 1, 1, 0, 32'h1000, 32'h100C};
    tab[1] = '{16'h8001, 32'h2000, 4'd13, 0, 1, 0, 1, 0, 32'h1FF8, 32'h1FF8};
    tab[2] = '{16'h0010, 32'h0100, 4'd13, 1, 1, 1, 1, 0, 32'h0104, 32'h0104};
    tab[3] = '{16'h0003, 32'h0100, 4'd13, 0, 0, 1, 1, 0, 32'h00FC, 32'h00F8};
    tab[4] = '{16'h000E, 32'h1000, 4'd13, 1, 0, 1, 1, 2, 32'h1000, 32'h100C};
    tab[5] = '{16'h0011, 32'h1000, 4'd4,  1, 0, 1, 1, 0, 32'h1000, 32'h1008};
    tab[6] = '{16'h0000, 32'h1000, 4'd0,  1, 0, 1, 1, 0, 32'h0000, 32'h0000};
    tab[7] = '{16'h00F0, 32'h3000, 4'd5,  1, 0, 0, 1, 0, 32'h3000, 32'h3010};

    clr = 1'b1; start = 1'b0; reg_list = '0; base = '0; base_idx = '0;
    up = 1'b0; pre = 1'b0; load = 1'b0; wb = 1'b0; mem_ready = 1'b1;
`ifdef LDM_ABORT_EN
    mem_abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_reg_sel", reg_sel, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_addr", wb_addr, 0);
`ifdef LDM_ABORT_EN
    chk("rst_aborted", aborted, 0);
`endif
    @(negedge clk);
    clr = 1'b0; mem_ready = 1'b0;

    for (int t = 0; t < 8; t++) begin
      run_xfer(tab[t].rl, tab[t].b, tab[t].bi, tab[t].u, tab[t].p, tab[t].l, tab[t].w,
               tab[t].mode, (t == 0), fa, wv);
      if (tab[t].rl != 16'd0) chk("tab_first_addr", fa, tab[t].exp_first);
      if (tab[t].rl != 16'd0 && tab[t].w) chk("tab_wb_addr", wv, tab[t].exp_wb);
    end

    // Asynchronous reset during the second beat of an LDMIA.
    @(negedge clk);
    reg_list = 16'h000E; base = 32'h1000; base_idx = 4'd13;
    up = 1'b1; pre = 1'b0; load = 1'b1; wb = 1'b1; start = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_clr_mem_req", mem_req, 1);
    chk("pre_clr_addr", addr, 32'h1004);
    clr = 1'b1;
    #1;
    chk("clr_busy", busy, 0);
    chk("clr_mem_req", mem_req, 0);
    chk("clr_rf_we", rf_we, 0);
    chk("clr_done", done, 0);
    chk("clr_reg_sel", reg_sel, 0);
    @(negedge clk);
    clr = 1'b0; mem_ready = 1'b0;
    run_xfer(16'h000E, 32'h1000, 4'd13, 1, 0, 1, 1, 0, 0, fa, wv);
    chk("post_clr_first", fa, 32'h1000);
    chk("post_clr_wb", wv, 32'h100C);

`ifdef LDM_ABORT_EN
    // Abort on the second beat: no load strobe, no write-back, done with aborted set.
    @(negedge clk);
    reg_list = 16'h000E; base = 32'h1000; base_idx = 4'd13;
    up = 1'b1; pre = 1'b0; load = 1'b1; wb = 1'b1; start = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("abt_beat1_rf_we", rf_we, 1);
    @(negedge clk);
    mem_abort = 1'b1;
    #1;
    chk("abt_beat2_addr", addr, 32'h1004);
    chk("abt_rf_we", rf_we, 0);
    @(negedge clk);
    mem_abort = 1'b0;
    #1;
    chk("abt_done", done, 1);
    chk("abt_wb_en", wb_en, 0);
    chk("abt_mem_req", mem_req, 0);
    chk("abt_aborted", aborted, 1);
    @(negedge clk);
    #1;
    chk("abt_idle_busy", busy, 0);
    chk("abt_hold", aborted, 1);
    mem_ready = 1'b0;
    run_xfer(16'h0001, 32'h40, 4'd13, 1, 0, 0, 0, 0, 0, fa, wv);
`endif

    for (int r = 0; r < 60; r++) begin
      logic [15:0] rl;
      rl = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rl = rl & 16'($urandom);
      if ($urandom_range(0, 7) == 0) rl = 16'd0;
      run_xfer(rl, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1, 1, fa, wv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
